// File: rtl/bin_to_bcd_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_driver_pkg
// Brief    : Shared types and constants for the binary-to-BCD display driver.
// Revision : 1.0 - initial release
// ============================================================================
package bin_to_bcd_driver_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [3:0] BCD_BLANK      = 4'hF;
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

  // ceil(width * log10(2)), using log10(2) ~= 0.30103
  function automatic int min_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_driver_add3.sv
`default_nettype none
// ============================================================================
// Module   : bcd_add3
// Brief    : Double-dabble digit correction: adds 3 to a BCD digit >= 5.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_add3
  import bin_to_bcd_driver_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= ADD3_THRESHOLD) ? digit_i + 4'd3 : digit_i;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_driver.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_driver
// Brief    : Sequential shift-and-add-3 binary-to-BCD converter with a
//            start/busy/done handshake. Optional macro BCD_LEADING_BLANK_EN
//            replaces leading zero digits with 4'hF on completion.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_driver
  import bin_to_bcd_driver_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     bcd_out
);

  localparam int SW = 4 * DIGITS;
  localparam int TW = SW + DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  if (DIGITS < min_digits(DATA_WIDTH)) begin : g_digits_check
    $error("bin_to_bcd_driver: DIGITS too small for DATA_WIDTH");
  end

  state_e          state_q, state_d;
  logic [TW-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [SW-1:0]   bcd_q, bcd_d;

  logic [SW-1:0]   w_adj;
  logic [TW-1:0]   w_shifted;
  logic [SW-1:0]   w_final;
  logic [SW-1:0]   w_result;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (shreg_q[DATA_WIDTH + 4*gi +: 4]),
      .digit_o (w_adj[4*gi +: 4])
    );
  end

  // The scratch MSB shifts out; the DIGITS constraint guarantees it is zero.
  assign w_shifted = {w_adj, shreg_q[DATA_WIDTH-1:0]} << 1;
  assign w_final   = w_shifted[TW-1 -: SW];

`ifdef BCD_LEADING_BLANK_EN
  logic w_seen;

  always_comb begin
    w_result = w_final;
    w_seen   = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (w_final[4*i +: 4] != 4'd0) w_seen = 1'b1;
      if (!w_seen) w_result[4*i +: 4] = BCD_BLANK;
    end
  end
`else
  assign w_result = w_final;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = {{SW{1'b0}}, bin_in};
          cnt_d   = CW'(DATA_WIDTH);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = w_shifted;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = w_result;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_driver
// Brief    : Self-checking bench for bin_to_bcd_driver against a decimal model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_driver;

  localparam int DW = 16;
  localparam int DG = 5;

  logic            clock;
  logic            reset;
  logic            start;
  logic [DW-1:0]   bin_in;
  logic            busy;
  logic            done;
  logic [4*DG-1:0] bcd_out;

  int total = 0;
  int bad   = 0;
  logic [4*DG-1:0] model_bcd = '0;

  bin_to_bcd_driver #(.DATA_WIDTH(DW), .DIGITS(DG)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Decimal digits by division; leading digits blanked when the macro is set.
  function automatic logic [4*DG-1:0] ref_bcd(input int unsigned v);
    logic [4*DG-1:0] r;
    int unsigned t;
    int top;
    r = '0;
    t = v;
    top = 0;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      if (t % 10 != 0) top = i;
      t = t / 10;
    end
`ifdef BCD_LEADING_BLANK_EN
    for (int i = 1; i < DG; i++) if (i > top) r[4*i +: 4] = 4'hF;
`endif
    return r;
  endfunction

  // One conversion; optionally pokes a second start at cycle poke_cyc.
  task automatic run_conv(input logic [DW-1:0] v, input int poke_cyc, input logic [DW-1:0] poke_val);
    int cyc;
    int busy_cnt;
    logic got;
    @(negedge clock);
    start  = 1'b1;
    bin_in = v;
    @(negedge clock);
    start  = 1'b0;
    bin_in = DW'($urandom);
    cyc = 0;
    busy_cnt = 0;
    got = 1'b0;
    while (!got && cyc <= 40) begin
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
      end else begin
        total++;
        if (bcd_out !== model_bcd) begin
          bad++;
          $display("FAIL hold v=%0d cyc=%0d: bcd_out=%h expected %h", v, cyc, bcd_out, model_bcd);
        end
        if (cyc == poke_cyc) begin
          start = 1'b1; bin_in = poke_val;
        end else if (cyc == poke_cyc + 1) begin
          start = 1'b0;
        end
        @(negedge clock);
        cyc++;
      end
    end
    start = 1'b0;
    model_bcd = ref_bcd(int'(v));
    total++;
    if (!got || cyc != DW) begin
      bad++;
      $display("FAIL latency v=%0d: got_done=%0b cycles=%0d expected %0d", v, got, cyc, DW);
    end
    total++;
    if (bcd_out !== model_bcd) begin
      bad++;
      $display("FAIL value v=%0d: bcd_out=%h expected %h", v, bcd_out, model_bcd);
    end
    total++;
    if (busy_cnt != DW || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy v=%0d: busy_cycles=%0d busy_at_done=%b expected %0d/0", v, busy_cnt, busy, DW);
    end
    @(negedge clock);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL pulse v=%0d: done=%b one cycle after pulse, expected 0", v, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bin_in = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== '0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b bcd_out=%h expected 0/0/0", busy, done, bcd_out);
    end
    model_bcd = '0;
  endtask

  task automatic test_values();
    logic [DW-1:0] vals [6] = '{16'd0, 16'd1234, 16'd65535, 16'd9, 16'd10, 16'd1005};
    foreach (vals[i]) run_conv(vals[i], -10, '0);
    for (int i = 0; i < 14; i++) run_conv(DW'($urandom), -10, '0);
  endtask

  task automatic test_ignore_while_busy();
    int extra;
    run_conv(16'd1234, 5, 16'd999);
    extra = 0;
    repeat (25) begin
      if (done || busy) extra++;
      @(negedge clock);
    end
    total++;
    if (extra != 0 || bcd_out !== ref_bcd(1234)) begin
      bad++;
      $display("FAIL ignore: extra_activity=%0d bcd_out=%h expected 0/%h", extra, bcd_out, ref_bcd(1234));
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int gap;
    logic got;
    @(negedge clock);
    start = 1'b1; bin_in = 16'd100;
    @(negedge clock);
    bin_in = 16'd42;
    cyc = 0; got = 1'b0;
    while (!got && cyc <= 40) begin
      if (done) got = 1'b1;
      else begin @(negedge clock); cyc++; end
    end
    model_bcd = ref_bcd(100);
    total++;
    if (!got || cyc != DW || bcd_out !== model_bcd) begin
      bad++;
      $display("FAIL b2b_first: done=%0b cycles=%0d bcd_out=%h expected %0d/%h", got, cyc, bcd_out, DW, model_bcd);
    end
    // start remains high through the done cycle, so the next job is accepted there
    @(negedge clock);
    gap = 1; got = 1'b0;
    while (!got && gap <= 40) begin
      if (done) got = 1'b1;
      else begin
        total++;
        if (bcd_out !== model_bcd) begin
          bad++;
          $display("FAIL b2b_hold gap=%0d: bcd_out=%h expected %h", gap, bcd_out, model_bcd);
        end
        @(negedge clock); gap++;
      end
    end
    start = 1'b0;
    model_bcd = ref_bcd(42);
    total++;
    if (!got || gap != DW + 1 || bcd_out !== model_bcd) begin
      bad++;
      $display("FAIL b2b_second: done=%0b gap=%0d bcd_out=%h expected %0d/%h", got, gap, bcd_out, DW + 1, model_bcd);
    end
    @(negedge clock);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stop: busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clock);
    start = 1'b1; bin_in = 16'd500;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    reset = 1'b1; start = 1'b1; bin_in = 16'd321;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    model_bcd = '0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== '0) begin
      bad++;
      $display("FAIL abort: busy=%b done=%b bcd_out=%h expected 0/0/0", busy, done, bcd_out);
    end
    seen = 0;
    repeat (20) begin
      if (done || busy || bcd_out !== '0) seen++;
      @(negedge clock);
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL abort_quiet: activity_cycles=%0d expected 0", seen);
    end
    run_conv(16'd7, -10, '0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bin_in = '0;
    test_reset();
    test_values();
    test_ignore_while_busy();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
